// File: rtl/clk_gate_en_ctrl_pkg.sv
// Shared types and helpers for the clock-gate enable controller.
// Holds the FSM state encoding, the reset state, and the
// counter-width helper used by the controller and its down-counter.
package clk_gate_ctrl_pkg;

    // The encoding is visible on cg_state, so the values are fixed.
    typedef enum logic [1:0] {
        CG_ON   = 2'd0,
        CG_HYST = 2'd1,
        CG_OFF  = 2'd2,
        CG_WAKE = 2'd3
    } cg_state_e;

    // The domain comes out of reset clocked.
    localparam cg_state_e CG_RST_STATE = CG_ON;

    // The counter must hold the larger of the two load values (N-1).
    // It is sized for N, which leaves one value of headroom.
    function automatic int cg_cnt_width(input int idle_hyst, input int wake_lat);
        int m;
        m = (idle_hyst > wake_lat) ? idle_hyst : wake_lat;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_gate_dncnt.sv
// Loadable down-counter shared by the hysteresis and wake phases.
// Ports:
//   clk      : free-running clock
//   rst      : asynchronous active-high reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; the count holds at 0 and never wraps
//   zero     : count equals 0
module clk_gate_dncnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clk_gate_en.sv
// Clock-gate enable controller: drives the en pin of the test-enabled
// clock-gate cell, one instance per gated domain, on the ungated clock.
// It gates off after IDLE_HYST idle edges. It ungates on activity and
// acknowledges a wake request once the gated clock has settled.
// Ports:
//   clk      : free-running ungated clock
//   rst      : asynchronous active-high reset (ON, gate_en=1, no ack)
//   busy     : domain activity, clock needed
//   force_on : CSR/debug override that keeps the clock enabled
//   wake_req : ungate request, held until wake_ack
//   wake_ack : gated clock is running and stable (registered)
//   gate_en  : clock-gate en pin (registered, glitch-free)
//   cg_state : current FSM state (0=ON, 1=HYST, 2=OFF, 3=WAKE)
module clk_gate_en_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_HYST = 16,
    parameter int WAKE_LAT  = 2,
    parameter int CNT_W     = cg_cnt_width(IDLE_HYST, WAKE_LAT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busy,
    input  logic       force_on,
    input  logic       wake_req,
    output logic       wake_ack,
    output logic       gate_en,
    output logic [1:0] cg_state
);

    localparam logic [CNT_W-1:0] HYST_LOAD = CNT_W'(IDLE_HYST - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_LAT - 1);

    cg_state_e        state;
    cg_state_e        nxt_state;
    logic             act;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    assign act = busy | force_on | wake_req;

    clk_gate_dncnt #(
        .CNT_W (CNT_W)
    ) u_dncnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        nxt_state = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        case (state)
            CG_ON: begin
                if (!act) begin
                    nxt_state = CG_HYST;
                    cnt_load  = 1'b1;
                    cnt_val   = HYST_LOAD;
                end
            end
            CG_HYST: begin
                // Activity wins over expiry and clears the count.
                if (act) begin
                    nxt_state = CG_ON;
                    cnt_load  = 1'b1;
                    cnt_val   = '0;
                end else if (cnt_zero) begin
                    nxt_state = CG_OFF;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            CG_OFF: begin
                if (act) begin
                    nxt_state = CG_WAKE;
                    cnt_load  = 1'b1;
                    cnt_val   = WAKE_LOAD;
                end
            end
            CG_WAKE: begin
                // act is ignored: a started wake always completes, so the
                // gate never bounces straight back off.
                if (cnt_zero) begin
                    nxt_state = CG_ON;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: nxt_state = CG_RST_STATE;
        endcase
    end

    // Outputs are registered from the next state. gate_en therefore
    // changes on the same edge as the state, and never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CG_RST_STATE;
            gate_en  <= 1'b1;
            wake_ack <= 1'b0;
        end else begin
            state    <= nxt_state;
            gate_en  <= (nxt_state != CG_OFF);
            wake_ack <= (nxt_state == CG_ON) & wake_req;
        end
    end

    assign cg_state = state;

endmodule

// File: tb/tb_clk_gate_en_ctrl.sv
module tb_clk_gate_en_ctrl;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       force_on;
    logic       wake_req;
    logic       wake_ack;
    logic       gate_en;
    logic [1:0] cg_state;

    // Observation vector {gate_en, wake_ack, cg_state}
    logic [3:0] obs;
    assign obs = {gate_en, wake_ack, cg_state};

    localparam logic [3:0] S_ON    = 4'b1000;
    localparam logic [3:0] S_ONACK = 4'b1100;
    localparam logic [3:0] S_HYST  = 4'b1001;
    localparam logic [3:0] S_OFF   = 4'b0010;
    localparam logic [3:0] S_WAKE  = 4'b1011;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    clk_gate_en_ctrl #(
        .IDLE_HYST (4),
        .WAKE_LAT  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .force_on (force_on),
        .wake_req (wake_req),
        .wake_ack (wake_ack),
        .gate_en  (gate_en),
        .cg_state (cg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; busy = 1'b1; force_on = 1'b0; wake_req = 1'b0;
        tick(); tick();
        chk_cnt++; if (obs !== S_ON) $display("FAIL reset_hold: got %b want %b", obs, S_ON); else pass_cnt++;
        rst = 1'b0;
        tick();
        chk_cnt++; if (obs !== S_ON) $display("FAIL reset_release_busy: got %b want %b", obs, S_ON); else pass_cnt++;
        busy = 1'b0;
        tick();
        chk_cnt++; if (obs !== S_HYST) $display("FAIL reset_pre_hyst: got %b want %b", obs, S_HYST); else pass_cnt++;
        tick();
        // Assert reset between edges; outputs must clear with no clock edge.
        #2 rst = 1'b1;
        #1;
        chk_cnt++; if (obs !== S_ON) $display("FAIL reset_async_mid_hyst: got %b want %b", obs, S_ON); else pass_cnt++;
        busy = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk_cnt++; if (obs !== S_ON) $display("FAIL reset_after_mid_hyst: got %b want %b", obs, S_ON); else pass_cnt++;
    endtask

    task automatic test_idle_gate();
        busy = 1'b0;
        tick();
        chk_cnt++; if (obs !== S_HYST) $display("FAIL idle_e0: got %b want %b", obs, S_HYST); else pass_cnt++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_cnt++; if (obs !== S_HYST) $display("FAIL idle_e%0d: got %b want %b", i, obs, S_HYST); else pass_cnt++;
        end
        tick();
        chk_cnt++; if (obs !== S_OFF) $display("FAIL idle_e4_off: got %b want %b", obs, S_OFF); else pass_cnt++;
    endtask

    task automatic test_wake();
        tick();
        chk_cnt++; if (obs !== S_OFF) $display("FAIL wake_stay_off: got %b want %b", obs, S_OFF); else pass_cnt++;
        wake_req = 1'b1;
        tick();
        chk_cnt++; if (obs !== S_WAKE) $display("FAIL wake_e0: got %b want %b", obs, S_WAKE); else pass_cnt++;
        tick();
        chk_cnt++; if (obs !== S_WAKE) $display("FAIL wake_e1: got %b want %b", obs, S_WAKE); else pass_cnt++;
        tick();
        chk_cnt++; if (obs !== S_ONACK) $display("FAIL wake_e2_ack: got %b want %b", obs, S_ONACK); else pass_cnt++;
        tick();
        chk_cnt++; if (obs !== S_ONACK) $display("FAIL wake_ack_hold: got %b want %b", obs, S_ONACK); else pass_cnt++;
        wake_req = 1'b0; busy = 1'b1;
        tick();
        chk_cnt++; if (obs !== S_ON) $display("FAIL wake_ack_drop: got %b want %b", obs, S_ON); else pass_cnt++;
    endtask

    task automatic test_busy_pulse();
        busy = 1'b0;
        tick();
        chk_cnt++; if (obs !== S_HYST) $display("FAIL pulse_e10: got %b want %b", obs, S_HYST); else pass_cnt++;
        tick();
        chk_cnt++; if (obs !== S_HYST) $display("FAIL pulse_e11: got %b want %b", obs, S_HYST); else pass_cnt++;
        busy = 1'b1;
        tick();
        chk_cnt++; if (obs !== S_ON) $display("FAIL pulse_e12_on: got %b want %b", obs, S_ON); else pass_cnt++;
        busy = 1'b0;
        tick();
        chk_cnt++; if (obs !== S_HYST) $display("FAIL pulse_reidle_e0: got %b want %b", obs, S_HYST); else pass_cnt++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_cnt++; if (obs !== S_HYST) $display("FAIL pulse_reidle_e%0d: got %b want %b", i, obs, S_HYST); else pass_cnt++;
        end
        tick();
        chk_cnt++; if (obs !== S_OFF) $display("FAIL pulse_reidle_off: got %b want %b", obs, S_OFF); else pass_cnt++;
    endtask

    task automatic test_wake_pulse();
        wake_req = 1'b1;
        tick();
        chk_cnt++; if (obs !== S_WAKE) $display("FAIL wpulse_e0: got %b want %b", obs, S_WAKE); else pass_cnt++;
        wake_req = 1'b0;
        tick();
        chk_cnt++; if (obs !== S_WAKE) $display("FAIL wpulse_e1: got %b want %b", obs, S_WAKE); else pass_cnt++;
        tick();
        chk_cnt++; if (obs !== S_ON) $display("FAIL wpulse_on_no_ack: got %b want %b", obs, S_ON); else pass_cnt++;
        // First edge sampling idle in ON enters HYST; OFF follows 4 edges later.
        for (int i = 0; i <= 3; i++) begin
            tick();
            chk_cnt++; if (obs !== S_HYST) $display("FAIL wpulse_hyst_e%0d: got %b want %b", i, obs, S_HYST); else pass_cnt++;
        end
        tick();
        chk_cnt++; if (obs !== S_OFF) $display("FAIL wpulse_regate: got %b want %b", obs, S_OFF); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        busy = 1'b1;
        tick(); tick(); tick();
        chk_cnt++; if (obs !== S_ON) $display("FAIL b2b_busy_wake_on: got %b want %b", obs, S_ON); else pass_cnt++;
        busy = 1'b0;
        tick();
        chk_cnt++; if (obs !== S_HYST) $display("FAIL b2b_hyst: got %b want %b", obs, S_HYST); else pass_cnt++;
        wake_req = 1'b1;
        tick();
        chk_cnt++; if (obs !== S_ONACK) $display("FAIL b2b_hyst_wake_ack: got %b want %b", obs, S_ONACK); else pass_cnt++;
        wake_req = 1'b0;
        tick();
        chk_cnt++; if (obs !== S_HYST) $display("FAIL b2b_drop: got %b want %b", obs, S_HYST); else pass_cnt++;
        wake_req = 1'b1;
        tick();
        chk_cnt++; if (obs !== S_ONACK) $display("FAIL b2b_reassert_ack: got %b want %b", obs, S_ONACK); else pass_cnt++;
        wake_req = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            tick();
            chk_cnt++; if (obs !== S_HYST) $display("FAIL b2b_hyst_e%0d: got %b want %b", i, obs, S_HYST); else pass_cnt++;
        end
        tick();
        chk_cnt++; if (obs !== S_OFF) $display("FAIL b2b_off: got %b want %b", obs, S_OFF); else pass_cnt++;
    endtask

    task automatic test_force_on();
        force_on = 1'b1;
        tick();
        chk_cnt++; if (obs !== S_WAKE) $display("FAIL force_wake_e0: got %b want %b", obs, S_WAKE); else pass_cnt++;
        tick();
        tick();
        chk_cnt++; if (obs !== S_ON) $display("FAIL force_on_entry: got %b want %b", obs, S_ON); else pass_cnt++;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk_cnt++; if (obs !== S_ON) $display("FAIL force_hold_c%0d: got %b want %b", i, obs, S_ON); else pass_cnt++;
        end
        force_on = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            tick();
            chk_cnt++; if (obs !== S_HYST) $display("FAIL force_rel_e%0d: got %b want %b", i, obs, S_HYST); else pass_cnt++;
        end
        tick();
        chk_cnt++; if (obs !== S_OFF) $display("FAIL force_rel_off: got %b want %b", obs, S_OFF); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wake();
        wake_req = 1'b1;
        tick();
        chk_cnt++; if (obs !== S_WAKE) $display("FAIL rstwake_pre: got %b want %b", obs, S_WAKE); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++; if (obs !== S_ON) $display("FAIL rstwake_async: got %b want %b", obs, S_ON); else pass_cnt++;
        wake_req = 1'b0; busy = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk_cnt++; if (obs !== S_ON) $display("FAIL rstwake_after: got %b want %b", obs, S_ON); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_idle_gate();
        test_wake();
        test_busy_pulse();
        test_wake_pulse();
        test_back_to_back();
        test_force_on();
        test_reset_mid_wake();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
